dense_l1_mem_loader: RTL and testbench

- Write-side companion to the dense layer-1 weight memory bank set: NUM_BANKS single-word-wide BRAMs, read in parallel by the dense layer.
- Accepts a valid/ready stream of 32-bit weight words and scatters them round-robin across the banks.
- Drives per-bank write enable with a shared address and shared data bus.
- Sits between the weight DMA / host stream and the write ports of the weight BRAMs.

---
 rtl/dense_l1_mem_loader_pkg.sv | 15 +
 rtl/dense_l1_mem_loader_if.sv | 23 ++
 rtl/dense_l1_mem_loader.sv | 100 ++++++++++
 tb/tb_dense_l1_mem_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_l1_mem_loader_pkg.sv
// Shared constants and FSM state type for the dense layer-1 weight memory loader.
package dense_mem_pkg;

  localparam int NUM_BANKS = 16;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/dense_l1_mem_loader_if.sv
// Weight stream (valid/ready) plus the shared BRAM write bus driven by the loader.
interface dense_l1_mem_loader_if;
  import dense_mem_pkg::*;

  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 s_last;
  logic                 s_ready;
  logic [NUM_BANKS-1:0] bram_we;
  logic [ADDR_W-1:0]    bram_addr;
  logic [DATA_W-1:0]    bram_din;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/dense_l1_mem_loader.sv
// Scatters a stream of weight words round-robin across NUM_BANKS BRAMs, filling
// num_rows addresses per bank starting at base_addr, with registered write ports.
module dense_l1_mem_loader
  import dense_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W:0]        num_rows,
  dense_l1_mem_loader_if.slave   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err_len
);

  loader_state_t       state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     rows_q;
  logic [BANK_W-1:0]   bank_cnt;
  logic [ADDR_W-1:0]   row_cnt;
  logic                accept;
  logic                last_bank;
  logic                last_row;
  logic                final_word;

  assign accept     = bus.s_valid & bus.s_ready;
  assign last_bank  = (bank_cnt == BANK_W'(NUM_BANKS - 1));
  // rows_q is never zero while in LOAD, so the subtraction cannot underflow here
  assign last_row   = ({1'b0, row_cnt} == (rows_q - 1'b1));
  assign final_word = last_bank & last_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      base_q        <= '0;
      rows_q        <= '0;
      bank_cnt      <= '0;
      row_cnt       <= '0;
      bus.s_ready   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      bus.bram_we <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            rows_q   <= num_rows;
            err_len  <= 1'b0;
            bank_cnt <= '0;
            row_cnt  <= '0;
            busy     <= 1'b1;
            if (num_rows == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= LOAD;
              bus.s_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            bus.bram_we   <= NUM_BANKS'(1) << bank_cnt;
            bus.bram_addr <= base_q + row_cnt;
            bus.bram_din  <= bus.s_data;
            // s_last must coincide exactly with the final word; either mismatch ends the job
            if (final_word || bus.s_last) begin
              state       <= DONE;
              done        <= 1'b1;
              bus.s_ready <= 1'b0;
              if (final_word ^ bus.s_last) begin
                err_len <= 1'b1;
              end
            end else if (last_bank) begin
              bank_cnt <= '0;
              row_cnt  <= row_cnt + 1'b1;
            end else begin
              bank_cnt <= bank_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_l1_mem_loader.sv
// Self-checking bench for dense_l1_mem_loader: directed jobs plus randomized data,
// gaps and s_last placement, checked against a word-index reference model.
module tb_dense_l1_mem_loader;
  import dense_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_rows;
  logic              busy;
  logic              done;
  logic              err_len;

  int compared   = 0;
  int mismatched = 0;

  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;

  dense_l1_mem_loader_if bus();

  dense_l1_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete job: word i lands in bank i%NUM_BANKS at base+i/NUM_BANKS.
  // last_idx >= 0 places an early s_last; final_last sets s_last on the true final word.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int rows, input int gap_mode,
                               input int last_idx, input bit final_last, input int ignore_at);
    int total;
    int end_idx;
    bit exp_err;
    int i;
    int cyc;
    int nwrites;
    bit v;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_addr;

    total   = rows * NUM_BANKS;
    end_idx = (last_idx >= 0 && last_idx < total - 1) ? last_idx : total - 1;
    exp_err = (end_idx != total - 1) || !final_last;
    i       = 0;
    cyc     = 0;
    nwrites = 0;

    start       = 1'b1;
    base_addr   = base;
    num_rows    = (ADDR_W+1)'(rows);
    bus.s_valid = 1'b0;
    step();
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    num_rows  = (ADDR_W+1)'($urandom);
    checkOutput("start_err_clear", err_len, 0);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_we", bus.bram_we, 0);

    if (rows == 0) begin
      checkOutput("zero_done", done, 1);
      checkOutput("zero_ready", bus.s_ready, 0);
      step();
      checkOutput("zero_done_after", done, 0);
      checkOutput("zero_busy_after", busy, 0);
      checkOutput("zero_we_after", bus.bram_we, 0);
      checkOutput("zero_err", err_len, 0);
      return;
    end

    checkOutput("start_ready", bus.s_ready, 1);
    checkOutput("start_done", done, 0);

    while (i <= end_idx && cyc < 4000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      data        = $urandom;
      bus.s_valid = v;
      bus.s_data  = data;
      if (!v)
        bus.s_last = 1'($urandom_range(0, 1));
      else if (i == end_idx)
        bus.s_last = (end_idx == total - 1) ? final_last : 1'b1;
      else
        bus.s_last = 1'b0;
      if (cyc == ignore_at) begin
        start     = 1'b1;
        base_addr = ADDR_W'($urandom);
        num_rows  = (ADDR_W+1)'($urandom_range(1, 5));
      end
      step();
      start = 1'b0;
      if (v) begin
        exp_addr = base + ADDR_W'(i / NUM_BANKS);
        checkOutput("we", bus.bram_we, 64'(NUM_BANKS'(1) << (i % NUM_BANKS)));
        checkOutput("addr", bus.bram_addr, exp_addr);
        checkOutput("din", bus.bram_din, data);
        last_addr = exp_addr;
        last_din  = data;
        nwrites++;
        if (i == end_idx) begin
          checkOutput("end_done", done, 1);
          checkOutput("end_ready", bus.s_ready, 0);
          checkOutput("end_err", err_len, exp_err);
        end else begin
          checkOutput("mid_done", done, 0);
          checkOutput("mid_ready", bus.s_ready, 1);
          checkOutput("mid_err", err_len, 0);
        end
        i++;
      end else begin
        checkOutput("gap_we", bus.bram_we, 0);
        checkOutput("gap_addr_hold", bus.bram_addr, last_addr);
        checkOutput("gap_din_hold", bus.bram_din, last_din);
        checkOutput("gap_done", done, 0);
      end
      cyc++;
    end
    if (cyc >= 4000) begin
      checkOutput("job_timeout", 1, 0);
    end

    bus.s_valid = 1'b0;
    step();
    checkOutput("post_busy", busy, 0);
    checkOutput("post_done", done, 0);
    checkOutput("post_we", bus.bram_we, 0);
    checkOutput("post_err", err_len, exp_err);
    checkOutput("write_count", nwrites, end_idx + 1);
  endtask

  initial begin
    int rows;
    int early;
    logic [DATA_W-1:0] data;

    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_rows    = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    last_addr   = '0;
    last_din    = '0;
    step();
    step();
    checkOutput("rst_we", bus.bram_we, 0);
    checkOutput("rst_addr", bus.bram_addr, 0);
    checkOutput("rst_din", bus.bram_din, 0);
    checkOutput("rst_ready", bus.s_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err_len, 0);
    rst = 1'b0;
    step();

    $display("[TB] single row job");
    applyStimulus(8'h10, 1, 0, -1, 1'b1, -1);
    $display("[TB] address wrap job");
    applyStimulus(8'hFE, 3, 0, -1, 1'b1, -1);
    $display("[TB] backpressure gaps");
    applyStimulus(ADDR_W'($urandom), 2, 1, -1, 1'b1, -1);
    $display("[TB] early last");
    applyStimulus(8'h40, 2, 0, 5, 1'b1, -1);
    step();
    checkOutput("err_sticky", err_len, 1);
    $display("[TB] zero rows");
    applyStimulus(8'h20, 0, 0, -1, 1'b1, -1);
    $display("[TB] start ignored during load");
    applyStimulus(8'h33, 2, 0, -1, 1'b1, 7);
    $display("[TB] missing last on final word");
    applyStimulus(ADDR_W'($urandom), 1, 2, -1, 1'b0, -1);

    $display("[TB] random jobs");
    for (int k = 0; k < 4; k++) begin
      rows  = $urandom_range(1, 3);
      early = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rows * NUM_BANKS - 1)) : -1;
      applyStimulus(ADDR_W'($urandom), rows, 2, early, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] reset mid-load");
    start     = 1'b1;
    base_addr = 8'h80;
    num_rows  = 9'd2;
    step();
    start = 1'b0;
    for (int w = 0; w < 5; w++) begin
      data        = $urandom;
      bus.s_valid = 1'b1;
      bus.s_data  = data;
      bus.s_last  = 1'b0;
      step();
      checkOutput("pre_rst_we", bus.bram_we, 64'(NUM_BANKS'(1) << w));
      checkOutput("pre_rst_din", bus.bram_din, data);
    end
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus.s_data = $urandom;
      step();
      checkOutput("midrst_we", bus.bram_we, 0);
      checkOutput("midrst_addr", bus.bram_addr, 0);
      checkOutput("midrst_din", bus.bram_din, 0);
      checkOutput("midrst_ready", bus.s_ready, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
    end
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus.s_data = $urandom;
      step();
      checkOutput("postrst_we", bus.bram_we, 0);
      checkOutput("postrst_ready", bus.s_ready, 0);
      checkOutput("postrst_busy", busy, 0);
      checkOutput("postrst_err", err_len, 0);
    end
    bus.s_valid = 1'b0;
    last_addr   = '0;
    last_din    = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
